// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and DBG ports; IDLE->WAIT->DONE, so one access takes at least 3 cycles.
// Requesters hold req until their done pulse; DBG is forced in after MAX_WAIT starved cycles, and WAIT aborts after TIMEOUT cycles.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_done_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_err_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_done_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int TCW = $clog2(TIMEOUT);

  logic [1:0]     state;
  logic           owner_dbg;
  logic [TCW-1:0] to_cnt;
  logic [WCW-1:0] dbg_wait_cnt;

  logic           dbg_starved;
  logic           grant_dbg;
  logic           issue;
  logic           timeout_hit;
  logic           finish;
  logic [DW-1:0]  fin_rdata;
  logic           dbg_in_flight;

  assign dbg_starved   = (dbg_wait_cnt >= WCW'(MAX_WAIT));
  assign grant_dbg     = dbg_req_i & (~cpu_req_i | dbg_starved);
  assign issue         = (state == S_IDLE) & (cpu_req_i | dbg_req_i);
  assign timeout_hit   = (to_cnt == TCW'(TIMEOUT - 1));
  // An ack arriving on the expiry cycle still wins over the abort.
  assign finish        = (state == S_WAIT) & (mem_ack_i | timeout_hit);
  assign fin_rdata     = mem_ack_i ? mem_rdata_i : '0;
  assign dbg_in_flight = owner_dbg & (state != S_IDLE);

  assign cpu_stall_o   = cpu_req_i & ~cpu_done_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      owner_dbg   <= 1'b0;
      to_cnt      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_done_o  <= 1'b0;
      cpu_rdata_o <= '0;
      cpu_err_o   <= 1'b0;
      dbg_done_o  <= 1'b0;
      dbg_rdata_o <= '0;
      dbg_err_o   <= 1'b0;
    end else begin
      cpu_done_o <= 1'b0;
      dbg_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            owner_dbg   <= grant_dbg;
            mem_we_o    <= grant_dbg ? dbg_we_i    : cpu_we_i;
            mem_addr_o  <= grant_dbg ? dbg_addr_i  : cpu_addr_i;
            mem_wdata_o <= grant_dbg ? dbg_wdata_i : cpu_wdata_i;
            mem_req_o   <= 1'b1;
            to_cnt      <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) begin
            mem_req_o <= 1'b0;
            state     <= S_DONE;
            if (owner_dbg) begin
              dbg_done_o  <= 1'b1;
              dbg_rdata_o <= fin_rdata;
              dbg_err_o   <= ~mem_ack_i;
            end else begin
              cpu_done_o  <= 1'b1;
              cpu_rdata_o <= fin_rdata;
              cpu_err_o   <= ~mem_ack_i;
            end
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Starvation counter: frozen while DBG owns the access, cleared on grant or when DBG backs off.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dbg_wait_cnt <= '0;
    end else if (!dbg_req_i || (issue && grant_dbg)) begin
      dbg_wait_cnt <= '0;
    end else if (!dbg_in_flight && !dbg_starved) begin
      dbg_wait_cnt <= dbg_wait_cnt + WCW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences,
// then random traffic checked against a schedule-based reference model.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic        cpu_done_o, cpu_err_o, cpu_stall_o;
  logic [31:0] cpu_rdata_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
  logic        dbg_done_o, dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b0;
    cpu_req_i = 1'b0; dbg_req_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  typedef struct {
    logic        cpu_req, dbg_req, ack;
    logic [31:0] ack_dat;
    logic        exp_mreq;
    logic [31:0] exp_addr;
    logic        exp_cdone, exp_ddone, exp_stall;
    logic [31:0] exp_crd, exp_drd;
  } vec_t;

  vec_t vecs[11];

  // Random-phase model: each access is a schedule (issue cycle, done cycle) fixed at grant time.
  int          g_issue, g_done, d_ack, w_len, cnt;
  logic        own_dbg, pend_err, e_mreq, e_cd, e_dd, idle_m, dbg_inflight, gd, granted;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata, pend_rd, exp_crd, exp_drd;

  initial begin
    int  hi, cpu_before, cpu_after;
    logic seen, dbg_seen;

    //            creq  dreq  ack   ack_dat        mreq  addr     cdone ddone stall crd            drd
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h22222222, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};

    // Reset values
    repeat (3) @(negedge clk_i);
    chk_b("rst_mem_req", mem_req_o, 1'b0);
    chk_b("rst_mem_we", mem_we_o, 1'b0);
    chk_w("rst_mem_addr", mem_addr_o, 32'h0);
    chk_w("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk_b("rst_cpu_done", cpu_done_o, 1'b0);
    chk_b("rst_dbg_done", dbg_done_o, 1'b0);
    chk_w("rst_cpu_rdata", cpu_rdata_o, 32'h0);
    chk_w("rst_dbg_rdata", dbg_rdata_o, 32'h0);
    chk_b("rst_cpu_err", cpu_err_o, 1'b0);
    chk_b("rst_dbg_err", dbg_err_o, 1'b0);
    chk_b("rst_stall", cpu_stall_o, 1'b0);
    rst_i = 1'b1;
    cpu_addr_i = 32'h100; cpu_wdata_i = 32'hC0C00001; cpu_we_i = 1'b0;
    dbg_addr_i = 32'h40;  dbg_wdata_i = 32'hD0D00002; dbg_we_i = 1'b0;
    @(negedge clk_i);

    // Vector table: CPU read with 2 WAIT cycles, CPU+DBG collision, spurious acks
    for (int i = 0; i < 11; i++) begin
      cpu_req_i   = vecs[i].cpu_req;
      dbg_req_i   = vecs[i].dbg_req;
      mem_ack_i   = vecs[i].ack;
      mem_rdata_i = vecs[i].ack_dat;
      @(negedge clk_i);
      chk_b($sformatf("vec%0d_mem_req", i), mem_req_o, vecs[i].exp_mreq);
      if (vecs[i].exp_mreq) chk_w($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].exp_addr);
      chk_b($sformatf("vec%0d_cpu_done", i), cpu_done_o, vecs[i].exp_cdone);
      chk_b($sformatf("vec%0d_dbg_done", i), dbg_done_o, vecs[i].exp_ddone);
      chk_b($sformatf("vec%0d_stall", i), cpu_stall_o, vecs[i].exp_stall);
      chk_w($sformatf("vec%0d_cpu_rdata", i), cpu_rdata_o, vecs[i].exp_crd);
      chk_w($sformatf("vec%0d_dbg_rdata", i), dbg_rdata_o, vecs[i].exp_drd);
      if (vecs[i].exp_cdone) chk_b($sformatf("vec%0d_cpu_err", i), cpu_err_o, 1'b0);
      if (vecs[i].exp_ddone) chk_b($sformatf("vec%0d_dbg_err", i), dbg_err_o, 1'b0);
    end
    mem_ack_i = 1'b0;

    // DBG write that is never acknowledged
    dbg_we_i = 1'b1; dbg_addr_i = 32'h40; dbg_wdata_i = 32'h12345678; dbg_req_i = 1'b1;
    hi = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        hi++;
        if (hi == 1) begin
          chk_b("to_mem_we", mem_we_o, 1'b1);
          chk_w("to_mem_addr", mem_addr_o, 32'h40);
          chk_w("to_mem_wdata", mem_wdata_o, 32'h12345678);
        end
      end
      if (dbg_done_o) seen = 1'b1;
    end
    chk_b("to_done_seen", seen, 1'b1);
    chk_w("to_req_cycles", hi, 32'd16);
    chk_b("to_dbg_err", dbg_err_o, 1'b1);
    chk_w("to_dbg_rdata", dbg_rdata_o, 32'h0);
    chk_b("to_cpu_done", cpu_done_o, 1'b0);
    dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    @(negedge clk_i);
    chk_b("to_idle_req", mem_req_o, 1'b0);
    chk_b("to_idle_done", dbg_done_o, 1'b0);
    @(negedge clk_i);
    chk_b("to_idle2_req", mem_req_o, 1'b0);

    // Continuous CPU traffic must not starve a held DBG request
    cpu_req_i = 1'b1; dbg_req_i = 1'b1;
    cpu_before = 0; cpu_after = 0; dbg_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      mem_ack_i   = mem_req_o;
      mem_rdata_i = $urandom;
      @(negedge clk_i);
      if (cpu_done_o) begin
        if (dbg_seen) cpu_after++;
        else cpu_before++;
      end
      if (dbg_done_o) begin
        dbg_seen = 1'b1;
        dbg_req_i = 1'b0;
      end
      if (cpu_after > 0) break;
    end
    chk_b("fair_dbg_granted", dbg_seen, 1'b1);
    chk_w("fair_cpu_before", cpu_before, 32'd3);
    chk_w("fair_cpu_after", cpu_after, 32'd1);
    cpu_req_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);

    // Reset in the middle of a WAIT
    cpu_req_i = 1'b1; cpu_addr_i = 32'h200;
    @(negedge clk_i);
    @(negedge clk_i);
    chk_b("rma_pre_req", mem_req_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk_b("rma_async_req", mem_req_o, 1'b0);
    chk_b("rma_async_done", cpu_done_o, 1'b0);
    cpu_req_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk_b("rma_hold_done", cpu_done_o, 1'b0);
      chk_b("rma_hold_req", mem_req_o, 1'b0);
    end
    rst_i = 1'b1;
    cpu_req_i = 1'b1; cpu_addr_i = 32'h204;
    @(negedge clk_i);
    chk_b("rma_new_req", mem_req_o, 1'b1);
    chk_w("rma_new_addr", mem_addr_o, 32'h204);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    chk_b("rma_new_done", cpu_done_o, 1'b1);
    chk_w("rma_new_rdata", cpu_rdata_o, 32'hCAFEF00D);
    chk_b("rma_new_err", cpu_err_o, 1'b0);
    chk_b("rma_new_stall", cpu_stall_o, 1'b0);
    cpu_req_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk_b("rma_after_done", cpu_done_o, 1'b0);

    // Random traffic against the schedule model
    reset_dut();
    g_issue = -10; g_done = -1; d_ack = 0; cnt = 0; own_dbg = 1'b0; pend_err = 1'b0;
    pend_rd = '0; exp_crd = '0; exp_drd = '0;
    lat_we = 1'b0; lat_addr = '0; lat_wdata = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      e_mreq = (k >= g_issue) && (k < g_done);
      e_cd   = (k == g_done) && !own_dbg;
      e_dd   = (k == g_done) && own_dbg;
      if (e_cd) exp_crd = pend_rd;
      if (e_dd) exp_drd = pend_rd;
      chk_b("rnd_mem_req", mem_req_o, e_mreq);
      chk_b("rnd_cpu_done", cpu_done_o, e_cd);
      chk_b("rnd_dbg_done", dbg_done_o, e_dd);
      chk_w("rnd_cpu_rdata", cpu_rdata_o, exp_crd);
      chk_w("rnd_dbg_rdata", dbg_rdata_o, exp_drd);
      if (e_mreq) begin
        chk_b("rnd_mem_we", mem_we_o, lat_we);
        chk_w("rnd_mem_addr", mem_addr_o, lat_addr);
        chk_w("rnd_mem_wdata", mem_wdata_o, lat_wdata);
      end
      if (e_cd) chk_b("rnd_cpu_err", cpu_err_o, pend_err);
      if (e_dd) chk_b("rnd_dbg_err", dbg_err_o, pend_err);

      // Requesters hold their command until their own done pulse
      if (e_cd || (!cpu_req_i && $urandom_range(0, 3) == 0)) begin
        cpu_req_i   = e_cd ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_we_i    = 1'($urandom_range(0, 1));
        cpu_addr_i  = $urandom;
        cpu_wdata_i = $urandom;
      end
      if (e_dd || (!dbg_req_i && $urandom_range(0, 3) == 0)) begin
        dbg_req_i   = e_dd ? 1'($urandom_range(0, 1)) : 1'b1;
        dbg_we_i    = 1'($urandom_range(0, 1));
        dbg_addr_i  = $urandom;
        dbg_wdata_i = $urandom;
      end

      idle_m       = (k > g_done);
      dbg_inflight = own_dbg && (k >= g_issue) && (k <= g_done);
      gd = 1'b0; granted = 1'b0;
      if (idle_m && (cpu_req_i || dbg_req_i)) begin
        gd        = dbg_req_i && (!cpu_req_i || cnt >= 8);
        granted   = 1'b1;
        own_dbg   = gd;
        lat_we    = gd ? dbg_we_i : cpu_we_i;
        lat_addr  = gd ? dbg_addr_i : cpu_addr_i;
        lat_wdata = gd ? dbg_wdata_i : cpu_wdata_i;
        d_ack     = int'($urandom_range(0, 19));
        w_len     = (d_ack > 15) ? 15 : d_ack;
        g_issue   = k + 1;
        g_done    = k + 2 + w_len;
        pend_err  = (d_ack > 15);
        pend_rd   = '0;
      end
      if (!granted && (k >= g_issue) && (k < g_done)) begin
        mem_ack_i = (k == g_issue + d_ack);
        mem_rdata_i = $urandom;
        if (mem_ack_i) pend_rd = mem_rdata_i;
      end else begin
        mem_ack_i   = ($urandom_range(0, 3) == 0);
        mem_rdata_i = $urandom;
      end
      if (!dbg_req_i || gd) cnt = 0;
      else if (!dbg_inflight && cnt < 8) cnt++;

      #1;
      chk_b("rnd_stall", cpu_stall_o, cpu_req_i & ~e_cd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
